uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receiver on the clk_50 domain. Default build is 8N1; defining UART_RX_PARITY_EN
// inserts a parity bit (even or odd, per PARITY_ODD) between the data and stop bits.
//
// Parameters:
//   CLKS_PER_BIT  clk_50 cycles per bit, 8..16383 (434 = 115200 baud at 50 MHz)
//   PARITY_ODD    0 = even parity, 1 = odd parity (only used with UART_RX_PARITY_EN)
//
// Ports:
//   clk_50   in   system clock
//   rst      in   synchronous reset, active-high
//   rx       in   asynchronous serial input, idle high
//   rx_data  out  last correctly received byte, held until the next good frame
//   rx_vld   out  one-cycle strobe, rx_data is new this cycle
//   rx_err   out  one-cycle strobe, frame rejected (bad stop bit or bad parity)
//   rx_busy  out  high while a frame is being received
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic       clk_50,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_vld,
   output logic       rx_err,
   output logic       rx_busy
);

   if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 16383) begin : g_bad_clks_per_bit
      $error("uart_rx: CLKS_PER_BIT must be in 8..16383");
   end
   if (PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_rx: PARITY_ODD must be 0 or 1");
   end

   localparam logic [13:0] BaudLast = 14'(CLKS_PER_BIT - 1);
   localparam logic [13:0] Half     = 14'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e      state_q, state_d;
   logic        rx_meta_q, rx_sync_q, rx_prev_q;
   logic [13:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        vld_q, vld_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic        par_err_q, par_err_d;
   logic        fall;

   assign fall = rx_prev_q & ~rx_sync_q;

   always_ff @(posedge clk_50) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= 8'h00;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         par_err_q <= par_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      data_d    = data_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;
      par_err_d = par_err_q;

      unique case (state_q)
         StIdle: begin
            if (fall) begin
               state_d   = StStart;
               baud_d    = '0;
               par_err_d = 1'b0;
            end
         end

         // Re-check the line at mid start bit so short glitches are dropped.
         StStart: begin
            if (baud_q == Half) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = rx_sync_q ? StIdle : StData;
            end else begin
               baud_d = baud_q + 14'd1;
            end
         end

         StData: begin
            if (baud_q == BaudLast) begin
               baud_d  = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end else begin
               baud_d = baud_q + 14'd1;
            end
         end

`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (baud_q == BaudLast) begin
               baud_d    = '0;
               par_err_d = rx_sync_q ^ (^shift_q) ^ 1'(PARITY_ODD);
               state_d   = StStop;
            end else begin
               baud_d = baud_q + 14'd1;
            end
         end
`endif

         // Leaving at mid stop bit lets a start edge right after the stop bit be caught.
         StStop: begin
            if (baud_q == BaudLast) begin
               baud_d  = '0;
               state_d = StIdle;
               if (rx_sync_q && !par_err_q) begin
                  data_d = shift_q;
                  vld_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               baud_d = baud_q + 14'd1;
            end
         end

         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   assign rx_data = data_q;
   assign rx_vld  = vld_q;
   assign rx_err  = err_q;
   assign rx_busy = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx. A short bit period keeps the run small;
// expected values below are derived from Cpb.
module tb_uart_rx;

   localparam int unsigned Cpb   = 64;
   localparam int unsigned Half  = Cpb / 2 - 1;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned FrameBits = 11;
`else
   localparam int unsigned FrameBits = 10;
`endif

   logic       clk_50 = 1'b0;
   logic       rst    = 1'b1;
   logic       rx     = 1'b1;
   logic [7:0] rx_data;
   logic       rx_vld;
   logic       rx_err;
   logic       rx_busy;

   int n_checks = 0;
   int n_errors = 0;

   // Monitor state, written only by the monitor process.
   int         cyc         = 0;
   int         vld_cnt     = 0;
   int         err_cnt     = 0;
   int         both_cnt    = 0;
   int         busy_cycles = 0;
   logic [7:0] rx_q[$];
   int         vld_times[$];

   uart_rx #(
      .CLKS_PER_BIT(Cpb),
      .PARITY_ODD  (0)
   ) dut (
      .clk_50 (clk_50),
      .rst    (rst),
      .rx     (rx),
      .rx_data(rx_data),
      .rx_vld (rx_vld),
      .rx_err (rx_err),
      .rx_busy(rx_busy)
   );

   always #10 clk_50 = ~clk_50;

   always @(negedge clk_50) begin
      cyc = cyc + 1;
      if (rx_vld) begin
         vld_cnt = vld_cnt + 1;
         rx_q.push_back(rx_data);
         vld_times.push_back(cyc);
      end
      if (rx_err) err_cnt = err_cnt + 1;
      if (rx_vld && rx_err) both_cnt = both_cnt + 1;
      if (rx_busy) busy_cycles = busy_cycles + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (Cpb) @(negedge clk_50);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(^d);
`endif
      send_bit(stop_bit);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par_bit);
      send_bit(1'b1);
   endtask
`endif

   initial begin
      int v0, e0, b0, n0;

      // Reset state
      repeat (3) @(negedge clk_50);
      rst = 1'b0;
      @(negedge clk_50);
      check("reset rx_data", int'(rx_data), 8'h00);
      check("reset rx_vld", int'(rx_vld), 0);
      check("reset rx_err", int'(rx_err), 0);
      check("reset rx_busy", int'(rx_busy), 0);
      repeat (10) @(negedge clk_50);

      // Single good frame
      v0 = vld_cnt; e0 = err_cnt;
      send_frame(8'hA5, 1'b1);
      send_bit(1'b1);
      check("a5 vld count", vld_cnt - v0, 1);
      check("a5 err count", err_cnt - e0, 0);
      check("a5 captured", int'(rx_q[rx_q.size() - 1]), 8'hA5);
      check("a5 rx_data", int'(rx_data), 8'hA5);
      check("a5 busy after", int'(rx_busy), 0);

      // Start glitch shorter than half a bit: busy only until mid-start check
      v0 = vld_cnt; e0 = err_cnt; b0 = busy_cycles;
      rx = 1'b0;
      repeat (20) @(negedge clk_50);
      rx = 1'b1;
      repeat (2 * Cpb) @(negedge clk_50);
      check("glitch busy cycles", busy_cycles - b0, Half + 1);
      check("glitch vld count", vld_cnt - v0, 0);
      check("glitch err count", err_cnt - e0, 0);
      check("glitch rx_data", int'(rx_data), 8'hA5);

      // Bad stop bit, then a good frame; the line returns high for one bit so a start edge exists
      v0 = vld_cnt; e0 = err_cnt;
      send_frame(8'h3C, 1'b0);
      check("3c err count", err_cnt - e0, 1);
      check("3c vld count", vld_cnt - v0, 0);
      check("3c rx_data kept", int'(rx_data), 8'hA5);
      send_bit(1'b1);
      send_frame(8'h11, 1'b1);
      check("11 vld count", vld_cnt - v0, 1);
      check("11 rx_data", int'(rx_data), 8'h11);

      // Back-to-back frames, no idle between
      n0 = vld_times.size();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_bit(1'b1);
      check("b2b vld count", vld_times.size() - n0, 2);
      check("b2b first byte", int'(rx_q[n0]), 8'h00);
      check("b2b second byte", int'(rx_q[n0 + 1]), 8'hFF);
      check("b2b spacing", vld_times[n0 + 1] - vld_times[n0], FrameBits * Cpb);

      // Reset in the middle of a frame (during data bit 4 of 8'hC3)
      v0 = vld_cnt; e0 = err_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(((8'hC3 >> i) & 1) != 0);
      rx = 1'b0;
      repeat (Cpb / 2) @(negedge clk_50);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk_50);
      rst = 1'b0;
      check("midrst rx_data", int'(rx_data), 8'h00);
      check("midrst rx_vld", int'(rx_vld), 0);
      check("midrst rx_err", int'(rx_err), 0);
      check("midrst rx_busy", int'(rx_busy), 0);
      repeat (2 * Cpb) @(negedge clk_50);
      send_frame(8'h55, 1'b1);
      send_bit(1'b1);
      check("55 vld count", vld_cnt - v0, 1);
      check("55 err count", err_cnt - e0, 0);
      check("55 rx_data", int'(rx_data), 8'h55);

`ifdef UART_RX_PARITY_EN
      // Even parity: 8'h01 needs parity bit 1
      v0 = vld_cnt; e0 = err_cnt;
      send_frame_par(8'h01, 1'b1);
      send_bit(1'b1);
      check("par good vld", vld_cnt - v0, 1);
      check("par good rx_data", int'(rx_data), 8'h01);
      v0 = vld_cnt; e0 = err_cnt;
      send_frame_par(8'h01, 1'b0);
      send_bit(1'b1);
      check("par bad err", err_cnt - e0, 1);
      check("par bad vld", vld_cnt - v0, 0);
`endif

      // Loopback-style stream of incrementing bytes
      n0 = rx_q.size(); e0 = err_cnt;
      for (int b = 1; b <= 16; b++) send_frame(8'(b), 1'b1);
      send_bit(1'b1);
      check("stream vld count", rx_q.size() - n0, 16);
      check("stream err count", err_cnt - e0, 0);
      for (int i = 0; i < 16; i++) begin
         if (n0 + i < rx_q.size()) check($sformatf("stream byte %0d", i), int'(rx_q[n0 + i]), i + 1);
         else check($sformatf("stream byte %0d missing", i), 0, i + 1);
      end
      check("stream busy after", int'(rx_busy), 0);

      check("vld and err together", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
